// File: rtl/hazard_pkg.sv
// Shared hazard-control types: controller state encoding and the x0 register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, branch flushes, memory-wait freeze with a
// watchdog that halts the pipeline, and saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_UsesRs1,
  input  logic             IF_ID_UsesRs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             EX_BranchTaken,
  input  logic             EX_MEM_MemAccess,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             ID_EX_Hold,
  output logic             EX_MEM_Hold,
  output logic             MEM_WB_Flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic freeze, load_use, hold_all, branch_act, stall_en;

  assign freeze = ((state_q == RUN) || (state_q == MEM_WAIT)) &&
                  EX_MEM_MemAccess && !dmem_ready;

  assign load_use = ID_EX_MemRead && (ID_EX_Rd != REG_ZERO) &&
                    ((IF_ID_UsesRs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                     (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

  assign hold_all   = (state_q == HALT) || freeze;
  assign branch_act = rst_n && !hold_all && EX_BranchTaken;

  // Control outputs are combinational; reset forces a flushed, stopped pipeline.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    ID_EX_Hold   = 1'b0;
    EX_MEM_Hold  = 1'b0;
    MEM_WB_Flush = 1'b0;
    if (!rst_n) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (hold_all) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Hold   = 1'b1;
      EX_MEM_Hold  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = freeze ? wait_cnt_q + WaitW'(1) : '0;
    mem_timeout_d = mem_timeout_q || (state_q == HALT);
    unique case (state_q)
      RUN: begin
        if (freeze) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else if (freeze && (wait_cnt_q == WaitLast)) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  // Halt cycles are not counted as stalls: the pipeline is dead, not waiting.
  assign stall_en = rst_n && !PC_Write && (state_q != HALT);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (stall_en),
    .cnt_o  (stall_cycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (branch_act),
    .cnt_o  (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned MaxWait = 4;
  localparam int unsigned CntW    = 6;
  localparam int          SatMax  = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      rs1 = '0, rs2 = '0, rd = '0;
  logic            u1 = 1'b0, u2 = 1'b0, memrd = 1'b0, br = 1'b0, acc = 1'b0, rdy = 1'b1;
  logic            pc_w, ifid_w, ifid_f, idex_f, idex_h, exmem_h, memwb_f, tmo;
  logic [CntW-1:0] stalls, flushes;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: halted flag, length of the current freeze run, timeout, counters.
  logic m_halted = 1'b0;
  int   m_run = 0;
  logic m_timeout = 1'b0;
  int   m_stalls = 0;
  int   m_flushes = 0;

  hazard_ctrl #(
    .MAX_WAIT (MaxWait),
    .CNT_W    (CntW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_Rs1        (rs1),
    .IF_ID_Rs2        (rs2),
    .IF_ID_UsesRs1    (u1),
    .IF_ID_UsesRs2    (u2),
    .ID_EX_MemRead    (memrd),
    .ID_EX_Rd         (rd),
    .EX_BranchTaken   (br),
    .EX_MEM_MemAccess (acc),
    .dmem_ready       (rdy),
    .PC_Write         (pc_w),
    .IF_ID_Write      (ifid_w),
    .IF_ID_Flush      (ifid_f),
    .ID_EX_Flush      (idex_f),
    .ID_EX_Hold       (idex_h),
    .EX_MEM_Hold      (exmem_h),
    .MEM_WB_Flush     (memwb_f),
    .mem_timeout      (tmo),
    .stall_cycles     (stalls),
    .flush_count      (flushes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold,
  // MEM_WB_Flush} from the priority rules.
  function automatic logic [6:0] model_ctl(input logic rstn, input logic halted);
    logic frz, lu;
    if (!rstn) return 7'b0011001;
    frz = !halted && acc && !rdy;
    lu  = memrd && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (halted || frz) return 7'b0000111;
    if (br) return 7'b1111000;
    if (lu) return 7'b0001000;
    return 7'b1100000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted  <= 1'b0;
      m_run     <= 0;
      m_timeout <= 1'b0;
      m_stalls  <= 0;
      m_flushes <= 0;
    end else begin : model_step
      logic [6:0] ctl;
      logic       frz;
      ctl = model_ctl(1'b1, m_halted);
      frz = !m_halted && acc && !rdy;
      if (!m_halted && !ctl[6] && m_stalls < SatMax) m_stalls <= m_stalls + 1;
      if (!m_halted && !frz && br && m_flushes < SatMax) m_flushes <= m_flushes + 1;
      if (m_halted) m_timeout <= 1'b1;
      if (frz) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= MaxWait) m_halted <= 1'b1;
      end else begin
        m_run <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("ctl", {pc_w, ifid_w, ifid_f, idex_f, idex_h, exmem_h, memwb_f},
          model_ctl(rst_n, m_halted));
    check("mem_timeout", tmo, m_timeout);
    check("stall_cycles", stalls, m_stalls);
    check("flush_count", flushes, m_flushes);
  end

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0;
    memrd = 1'b0; br = 1'b0; acc = 1'b0; rdy = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    check("rst_pc_write", pc_w, 1'b0);
    check("rst_ifid_flush", ifid_f, 1'b1);
    check("rst_memwb_flush", memwb_f, 1'b1);
    check("rst_stalls", stalls, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Load-use on rs2 costs one bubble.
    memrd = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b1;
    #3;
    check("lu_pc_write", pc_w, 1'b0);
    check("lu_ifid_write", ifid_w, 1'b0);
    check("lu_idex_flush", idex_f, 1'b1);
    cyc();
    idle();
    #3;
    check("lu_after_pc_write", pc_w, 1'b1);
    check("lu_stalls", stalls, 1);

    // x0 load or unused source: no stall.
    memrd = 1'b1; rd = 5'd0; rs2 = 5'd0; u2 = 1'b1;
    #1;
    check("rd0_no_stall", pc_w, 1'b1);
    rd = 5'd7; rs2 = 5'd7; u2 = 1'b0;
    #1;
    check("nouse_no_stall", pc_w, 1'b1);
    cyc();

    // Branch overrides load-use.
    memrd = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b1; br = 1'b1;
    #3;
    check("br_pc_write", pc_w, 1'b1);
    check("br_ifid_flush", ifid_f, 1'b1);
    check("br_idex_flush", idex_f, 1'b1);
    cyc();
    idle();
    #3;
    check("br_flush_count", flushes, 1);
    check("br_stalls_same", stalls, 1);

    // Three wait cycles, then ready.
    acc = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("wait_memwb_flush", memwb_f, 1'b1);
      check("wait_pc_write", pc_w, 1'b0);
      cyc();
    end
    rdy = 1'b1;
    #3;
    check("ready_pc_write", pc_w, 1'b1);
    check("ready_memwb_flush", memwb_f, 1'b0);
    cyc();
    idle();
    #3;
    check("wait_timeout", tmo, 1'b0);
    check("wait_stalls", stalls, 4);

    // Watchdog: four freeze cycles then HALT; a branch there is ignored.
    acc = 1'b1; rdy = 1'b0;
    repeat (4) cyc();
    br = 1'b1;
    #3;
    check("halt_pc_write", pc_w, 1'b0);
    check("halt_branch_ignored", ifid_f, 1'b0);
    check("halt_timeout_early", tmo, 1'b0);
    cyc();
    #3;
    check("halt_timeout", tmo, 1'b1);
    check("halt_flush_count", flushes, 1);
    check("halt_stalls", stalls, 8);

    // Asynchronous reset while halted.
    rst_n = 1'b0;
    #1;
    check("areset_pc_write", pc_w, 1'b0);
    check("areset_ifid_flush", ifid_f, 1'b1);
    check("areset_timeout", tmo, 1'b0);
    check("areset_stalls", stalls, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    #3;
    check("post_reset_pc_write", pc_w, 1'b1);
    check("post_reset_timeout", tmo, 1'b0);

    // Randomized traffic with periodic forced memory stalls and async resets.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      u1    = 1'($urandom_range(0, 1));
      u2    = 1'($urandom_range(0, 1));
      memrd = 1'($urandom_range(0, 1));
      br    = ($urandom_range(0, 4) == 0);
      acc   = ($urandom_range(0, 4) < 2);
      rdy   = ($urandom_range(0, 9) < 7);
      if ((i % 150) >= 140) begin
        acc = 1'b1;
        rdy = 1'b0;
      end
      if ((i % 150) == 147) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
